sync_regen: RTL
===============

# sync_regen

Camera-to-display sync regenerator. It sits between the CMOS camera capture interface and the video output path. It rebuilds clean hsync/vsync/de timing with pixel coordinates from the camera's `cam_href`/`cam_vsync`. Active lines stay phase-locked to camera href. Vertical blanking lines are free-run using the measured camera line period. Parameters set timing and output polarity. It also reports lock and error status.

## Interface
Parameters:
- `H_ACT`, 1280: active pixels per line
- `H_FP`, 220: horizontal front porch, clocks
- `H_SYNC`, 40: hsync width, clocks
- `V_ACT`, 720: active lines per frame
- `V_FP`, 18: blank lines before vsync
- `V_SYNC`, 40: vsync width, lines
- `V_BP`, 2: blank lines after vsync
- `HS_POL`, 1: hsync active level
- `VS_POL`, 1: vsync active level
- `LINE_W`, 16: width of the line-period counter

Ports (clock domain: `clk` only; reset: synchronous, active-high `rst`):
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous active-high reset
- `cam_href`  in  1  camera line valid
- `cam_vsync`  in  1  camera frame sync, active high
- `hsync`  out  1  regenerated hsync, level per HS_POL
- `vsync`  out  1  regenerated vsync, level per VS_POL
- `de`  out  1  data enable
- `x`  out  $clog2(H_ACT)  pixel index, valid while de
- `y`  out  $clog2(V_ACT)  line index, valid while de
- `locked`  out  1  frame-aligned and error-free
- `line_len`  out  LINE_W  last measured href-rise to href-rise period, clocks
- `err_short`  out  1  one-cycle pulse: href rise during ACT/FP/SYNC
- `err_timeout`  out  1  one-cycle pulse: watchdog expiry

## Operation
- `cam_href` is registered once as `href_d`. `href_rise = cam_href & ~href_d`. `cam_vsync` gets the same treatment, giving `vs_rise`.
- `vs_rise` sets `frame_pend`. Entering ACT with `frame_pend` set clears it.
- Line meter `lcnt` increments every clock and saturates at all-ones. On `href_rise`, `line_len <= lcnt+1` and `lcnt <= 0`.
- Minimum line length `L_MIN = H_ACT+H_FP+H_SYNC`. Blank-line length `L_BLK = max(line_len, L_MIN)`.
- FSM states: IDLE, ACT, FP, SYNC, WAIT, VBLK.
  - IDLE → ACT: `href_rise` while `frame_pend`. Sets y=0, x=0, `locked=1`.
  - ACT: `de=1` for H_ACT clocks, x increments 0..H_ACT-1. Then → FP.
  - FP: H_FP clocks, then → SYNC.
  - SYNC: hsync active for H_SYNC clocks. Then → VBLK if y==V_ACT-1, else → WAIT.
  - WAIT → ACT: on `href_rise`. If `frame_pend`, y=0; else y+1.
  - VBLK: free-runs blank lines of L_BLK clocks each, with blank-line counter `vb` from 0.
    - hsync is active at line offsets H_ACT+H_FP .. L_MIN-1.
    - vsync is active for `vb` in V_FP .. V_FP+V_SYNC-1.
    - After V_FP+V_SYNC+V_BP lines → IDLE.
- Resync during VBLK: `href_rise` with `frame_pend` set aborts VBLK and goes → ACT with y=0. vsync deasserts immediately.
- Short line: `href_rise` in ACT/FP/SYNC does the following:
  - pulses `err_short` and clears `locked`
  - deasserts hsync
  - restarts ACT, with y=0 if `frame_pend`, else y+1 (y wraps to 0 past V_ACT-1)
- `href_rise` in IDLE without `frame_pend` is ignored.
- Reset values: hsync=~HS_POL, vsync=~VS_POL, de=0, x=0, y=0, locked=0, line_len=0, err_short=0, err_timeout=0. State is IDLE and `frame_pend` is 0.

## Timing
- All outputs are registered.
- `cam_href` first sampled high at edge n: `de`=1 and x=0 at edge n+1.
- `de` stays high for exactly H_ACT clocks.
- hsync asserts H_ACT+H_FP clocks after `de` rises and lasts H_SYNC clocks.
- `vs_rise` and `href_rise` on the same clock: `frame_pend` is set first, so the transition uses y=0.
- `line_len` updates the clock after `href_rise`. It holds the saturated value if no href edge arrives for 2^LINE_W clocks.
- Reset asserted mid-line forces reset values on the next edge, regardless of state.

## Configuration
- `SYNC_REGEN_WATCHDOG_EN` defined:
  - In WAIT, a counter runs from state entry.
  - If it reaches 2·L_BLK with no `href_rise`, the block pulses `err_timeout`, clears `locked`, drives `de=0` and inactive syncs, and goes → IDLE.
- Not defined: WAIT holds indefinitely, and `err_timeout` is tied 0.

## Test plan
- Nominal frame, 720 lines of 1280 href clocks at a 1600-clock period → 720 de pulses of 1280 clocks. x reaches 1279, y reaches 719. Then 60 blank lines of 1600 clocks with vsync active on lines 18..57. `locked`=1 and `line_len`=1600.
- First href sampled at edge n → de=1 and x=0 at edge n+1. hsync is active over clocks n+1501..n+1540.
- Short line: href rises again 1000 clocks after the previous rise → `err_short` 1-cycle pulse, `locked`=0, y increments, de restarts.
- Camera `line_len`=1400 < L_MIN=1540 → blank lines are 1540 clocks long.
- New `cam_vsync` plus href arriving during VBLK line 30 → vsync deasserts, and y=0 with de the next clock.
- With `SYNC_REGEN_WATCHDOG_EN` and `line_len`=1600: href stops after line 100 → `err_timeout` pulses 3200 clocks after WAIT entry, `locked`=0, state IDLE. Without the macro: `de` stays 0 and `err_timeout` stays 0.

Source files
------------

// File: rtl/sync_regen_if.sv
// sync_regen_if: camera-in / video-out bundle for the sync regenerator.
//   cam_href, cam_vsync           : camera line valid and frame sync (active high)
//   hsync, vsync, de              : regenerated video timing
//   x, y                          : pixel/line coordinates, valid while de
//   locked, line_len              : status and last measured camera line period
//   err_short, err_timeout        : one-cycle error pulses
// Modports: master = camera/video side (drives cam_*), slave = sync_regen.
interface sync_regen_if #(
  parameter int H_ACT  = 1280,
  parameter int V_ACT  = 720,
  parameter int LINE_W = 16
);
  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  logic              cam_href;
  logic              cam_vsync;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              locked;
  logic [LINE_W-1:0] line_len;
  logic              err_short;
  logic              err_timeout;

  modport master (
    output cam_href, cam_vsync,
    input  hsync, vsync, de, x, y, locked, line_len, err_short, err_timeout
  );

  modport slave (
    input  cam_href, cam_vsync,
    output hsync, vsync, de, x, y, locked, line_len, err_short, err_timeout
  );
endinterface

// File: rtl/sync_regen.sv
// sync_regen: rebuilds clean hsync/vsync/de plus x/y coordinates from camera
// href/vsync. Active lines are phase-locked to camera href rises; vertical
// blanking lines free-run at max(measured line period, minimum line length).
// Ports:
//   clk  : pixel clock
//   rst  : synchronous active-high reset
//   bus  : sync_regen_if.slave (cam_href/cam_vsync in; timing, coordinates,
//          locked, line_len, err_short, err_timeout out)
// Optional feature: define SYNC_REGEN_WATCHDOG_EN to abort a WAIT state that
// sees no href rise within two blank-line periods (err_timeout pulse).
module sync_regen #(
  parameter int H_ACT  = 1280,
  parameter int H_FP   = 220,
  parameter int H_SYNC = 40,
  parameter int V_ACT  = 720,
  parameter int V_FP   = 18,
  parameter int V_SYNC = 40,
  parameter int V_BP   = 2,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int LINE_W = 16
) (
  input logic         clk,
  input logic         rst,
  sync_regen_if.slave bus
);
  localparam int XW     = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW     = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int V_TOT  = V_FP + V_SYNC + V_BP;
  localparam int VBW    = $clog2(V_TOT + 1);

  localparam logic [LINE_W-1:0] L_MIN    = LINE_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [LINE_W-1:0] ACT_END  = LINE_W'(H_ACT - 1);
  localparam logic [LINE_W-1:0] FP_END   = LINE_W'(H_ACT + H_FP - 1);
  localparam logic [LINE_W-1:0] HS_START = LINE_W'(H_ACT + H_FP);
  localparam logic [YW-1:0]     Y_LAST   = YW'(V_ACT - 1);
  localparam logic [VBW-1:0]    VB_LAST  = VBW'(V_TOT - 1);
  localparam logic [VBW-1:0]    VS_FIRST = VBW'(V_FP);
  localparam logic [VBW-1:0]    VS_END   = VBW'(V_FP + V_SYNC);
  // Blank-line counter value for the tail of the last active line that is
  // padded out to L_BLK before blank line 0 begins; increments wrap it to 0.
  localparam logic [VBW-1:0]    VB_PRE   = '1;

  typedef enum logic [2:0] {S_IDLE, S_ACT, S_FP, S_SYNC, S_WAIT, S_VBLK} state_t;

  function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic [LINE_W-1:0] hc_q, hc_d;
  logic [VBW-1:0]    vb_q, vb_d;
  logic [LINE_W-1:0] lcnt_q, lcnt_d;
  logic [LINE_W-1:0] line_len_q, line_len_d;
  logic              frame_pend_q, frame_pend_d;
  logic              href_q, vsin_q;
  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              locked_q, locked_d;
  logic              err_short_q, err_short_d;

  logic              href_rise, vs_rise, pend, enter_act, hs_on, vs_on;
  logic [YW-1:0]     y_inc;
  logic [LINE_W-1:0] l_blk;

  assign href_rise = bus.cam_href & ~href_q;
  assign vs_rise   = bus.cam_vsync & ~vsin_q;
  // A vsync rise on the same clock as an href rise already counts as pending.
  assign pend      = frame_pend_q | vs_rise;
  assign y_inc     = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
  assign l_blk     = (line_len_q > L_MIN) ? line_len_q : L_MIN;

`ifdef SYNC_REGEN_WATCHDOG_EN
  logic [LINE_W:0] wd_q, wd_d;
  logic [LINE_W:0] wd_lim;
  logic            err_timeout_q, err_timeout_d;
  assign wd_lim = {l_blk, 1'b0} - 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    hc_d         = hc_q;
    vb_d         = vb_q;
    y_d          = y_q;
    locked_d     = locked_q;
    err_short_d  = 1'b0;
    frame_pend_d = pend;
    enter_act    = 1'b0;
`ifdef SYNC_REGEN_WATCHDOG_EN
    wd_d          = wd_q;
    err_timeout_d = 1'b0;
`endif

    if (href_rise) begin
      line_len_d = sat_inc(lcnt_q);
      lcnt_d     = '0;
    end else begin
      line_len_d = line_len_q;
      lcnt_d     = sat_inc(lcnt_q);
    end

    case (state_q)
      S_IDLE: begin
        if (href_rise && pend) begin
          enter_act = 1'b1;
          y_d       = '0;
          locked_d  = 1'b1;
        end
      end
      S_ACT, S_FP, S_SYNC: begin
        if (href_rise) begin
          // Camera line arrived early: restart the active line at once.
          enter_act   = 1'b1;
          err_short_d = 1'b1;
          locked_d    = 1'b0;
          y_d         = pend ? '0 : y_inc;
        end else begin
          hc_d = hc_q + 1'b1;
          if (state_q == S_ACT && hc_q == ACT_END) begin
            state_d = S_FP;
          end else if (state_q == S_FP && hc_q == FP_END) begin
            state_d = S_SYNC;
          end else if (state_q == S_SYNC && hc_q == L_MIN - 1'b1) begin
            if (y_q == Y_LAST) begin
              state_d = S_VBLK;
              if (l_blk == L_MIN) begin
                hc_d = '0;
                vb_d = '0;
              end else begin
                hc_d = L_MIN;
                vb_d = VB_PRE;
              end
            end else begin
              state_d = S_WAIT;
`ifdef SYNC_REGEN_WATCHDOG_EN
              wd_d    = '0;
`endif
            end
          end
        end
      end
      S_WAIT: begin
        if (href_rise) begin
          enter_act = 1'b1;
          y_d       = pend ? '0 : y_inc;
        end
`ifdef SYNC_REGEN_WATCHDOG_EN
        else if (wd_q == wd_lim) begin
          state_d       = S_IDLE;
          err_timeout_d = 1'b1;
          locked_d      = 1'b0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_VBLK: begin
        if (href_rise && pend) begin
          enter_act = 1'b1;
          y_d       = '0;
        end else if (hc_q >= l_blk - 1'b1) begin
          hc_d = '0;
          if (vb_q == VB_LAST) state_d = S_IDLE;
          else                 vb_d    = vb_q + 1'b1;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_act) begin
      state_d      = S_ACT;
      hc_d         = '0;
      frame_pend_d = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    hs_on = (state_d == S_SYNC) ||
            (state_d == S_VBLK && hc_d >= HS_START && hc_d < L_MIN);
    vs_on = (state_d == S_VBLK) && (vb_d >= VS_FIRST) && (vb_d < VS_END);
    hs_d  = hs_on ? HS_POL : ~HS_POL;
    vs_d  = vs_on ? VS_POL : ~VS_POL;
    de_d  = (state_d == S_ACT);
    x_d   = de_d ? hc_d[XW-1:0] : x_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_pend_q <= 1'b0;
      href_q       <= 1'b0;
      vsin_q       <= 1'b0;
      lcnt_q       <= '0;
      line_len_q   <= '0;
      hs_q         <= ~HS_POL;
      vs_q         <= ~VS_POL;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      locked_q     <= 1'b0;
      err_short_q  <= 1'b0;
`ifdef SYNC_REGEN_WATCHDOG_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frame_pend_q <= frame_pend_d;
      href_q       <= bus.cam_href;
      vsin_q       <= bus.cam_vsync;
      lcnt_q       <= lcnt_d;
      line_len_q   <= line_len_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      de_q         <= de_d;
      x_q          <= x_d;
      y_q          <= y_d;
      locked_q     <= locked_d;
      err_short_q  <= err_short_d;
`ifdef SYNC_REGEN_WATCHDOG_EN
      err_timeout_q <= err_timeout_d;
`endif
    end
    hc_q <= hc_d;
    vb_q <= vb_d;
`ifdef SYNC_REGEN_WATCHDOG_EN
    wd_q <= wd_d;
`endif
  end

  assign bus.hsync     = hs_q;
  assign bus.vsync     = vs_q;
  assign bus.de        = de_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.locked    = locked_q;
  assign bus.line_len  = line_len_q;
  assign bus.err_short = err_short_q;
`ifdef SYNC_REGEN_WATCHDOG_EN
  assign bus.err_timeout = err_timeout_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule
